reg_file_2r1w_sb: RTL and testbench

Parametrised register file for the pipelined CPU datapath. It replaces the single-port, select-shared 8x16 bank with a 2-read/1-write file. Reads are registered and use write-to-read bypass. A per-register scoreboard lets the decode stage detect RAW hazards and stall. It sits between decode (read/reserve) and writeback (write).

---
 rtl/reg_file_2r1w_sb_if.sv | 39 +++
 rtl/reg_file_2r1w_sb.sv | 95 +++++++++
 tb/tb_reg_file_2r1w_sb.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_2r1w_sb_if.sv
// Bus between the datapath stages and the 2-read/1-write register file.
// Writeback drives the write strobe. Decode drives the reads and reservations
// and receives the read data and the hazard flags.
interface reg_file_2r1w_sb_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en_a;
  logic [AW-1:0]    rd_addr_a;
  logic             rd_en_b;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             busy_a;
  logic             busy_b;
  logic             stall;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             rsv_err;

  // The pipeline side: it issues requests and consumes data and hazard flags.
  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output rsv_en, rsv_addr,
    input  rd_data_a, rd_data_b, busy_a, busy_b, stall, rsv_err
  );

  // The register file side.
  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  rsv_en, rsv_addr,
    output rd_data_a, rd_data_b, busy_a, busy_b, stall, rsv_err
  );
endinterface

// File: rtl/reg_file_2r1w_sb.sv
// Two-read/one-write register file with registered reads and write-to-read
// bypass. A per-register busy scoreboard lets decode detect RAW hazards.
// A reservation marks a pending producer, and the matching write clears it.
module reg_file_2r1w_sb #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int AW      = $clog2(DEPTH),
  parameter bit ZERO_R0 = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  reg_file_2r1w_sb_if.slave bus
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             rsvErr_q;
  logic             rsvErr_d;
  logic [WIDTH-1:0] rdDataA_q;
  logic [WIDTH-1:0] rdDataA_d;
  logic [WIDTH-1:0] rdDataB_q;
  logic [WIDTH-1:0] rdDataB_d;
  logic             wrEff;
  logic             rsvEff;
  logic             wrHitsA;
  logic             wrHitsB;

  // With ZERO_R0, register 0 is hard-wired, so writes to it and reservations
  // of it are dropped here. This keeps the rest of the logic unaware of the mode.
  assign wrEff   = bus.wr_en && !(ZERO_R0 && (bus.wr_addr == '0));
  assign rsvEff  = bus.rsv_en && !(ZERO_R0 && (bus.rsv_addr == '0));
  assign wrHitsA = bus.wr_en && (bus.wr_addr == bus.rd_addr_a);
  assign wrHitsB = bus.wr_en && (bus.wr_addr == bus.rd_addr_b);

  // A register being written this cycle is never busy, because the bypass supplies it.
  assign bus.busy_a = bus.rd_en_a && busy_q[bus.rd_addr_a] && !wrHitsA;
  assign bus.busy_b = bus.rd_en_b && busy_q[bus.rd_addr_b] && !wrHitsB;
  assign bus.stall  = bus.busy_a || bus.busy_b;

  assign bus.rd_data_a = rdDataA_q;
  assign bus.rd_data_b = rdDataB_q;
  assign bus.rsv_err   = rsvErr_q;

  // Scoreboard update: the write clears first and the reserve sets afterwards,
  // so a newer producer reserved in the same cycle keeps the register busy.
  always_comb begin
    busy_d   = busy_q;
    rsvErr_d = rsvErr_q;
    if (wrEff) begin
      busy_d[bus.wr_addr] = 1'b0;
    end
    if (rsvEff) begin
      busy_d[bus.rsv_addr] = 1'b1;
      if (busy_q[bus.rsv_addr] && !(wrEff && (bus.wr_addr == bus.rsv_addr))) begin
        rsvErr_d = 1'b1;
      end
    end
  end

  // Read muxes: a disabled port returns 0, r0 returns 0 in ZERO_R0 mode,
  // and a same-cycle write to the address is forwarded ahead of storage.
  always_comb begin
    rdDataA_d = '0;
    rdDataB_d = '0;
    if (bus.rd_en_a && !(ZERO_R0 && (bus.rd_addr_a == '0))) begin
      rdDataA_d = wrHitsA ? bus.wr_data : mem_q[bus.rd_addr_a];
    end
    if (bus.rd_en_b && !(ZERO_R0 && (bus.rd_addr_b == '0))) begin
      rdDataB_d = wrHitsB ? bus.wr_data : mem_q[bus.rd_addr_b];
    end
  end

  // State registers: storage, scoreboard, sticky error and read data all clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q    <= '0;
      rsvErr_q  <= 1'b0;
      rdDataA_q <= '0;
      rdDataB_q <= '0;
    end else begin
      if (wrEff) begin
        mem_q[bus.wr_addr] <= bus.wr_data;
      end
      busy_q    <= busy_d;
      rsvErr_q  <= rsvErr_d;
      rdDataA_q <= rdDataA_d;
      rdDataB_q <= rdDataB_d;
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w_sb.sv
// Testbench for reg_file_2r1w_sb: a table of per-cycle vectors for a plain
// instance and for a ZERO_R0 instance, plus a hand-written mid-operation reset.
// Expected read data goes into a queue when a vector is driven, and it is
// popped and compared once the registered outputs update.
module tb_reg_file_2r1w_sb;

  logic clk;
  logic rst_n;
  int   errCount;
  int   checkCount;

  reg_file_2r1w_sb_if #(.WIDTH(16), .AW(3)) mBus ();
  reg_file_2r1w_sb_if #(.WIDTH(16), .AW(3)) zBus ();

  reg_file_2r1w_sb #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1'b0)) dutMain (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (mBus)
  );

  reg_file_2r1w_sb #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1'b1)) dutZero (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (zBus)
  );

  typedef struct packed {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        rea;
    logic [2:0]  raa;
    logic        reb;
    logic [2:0]  rab;
    logic        rse;
    logic [2:0]  rsa;
    logic        busyA;
    logic        busyB;
    logic        stall;
    logic [15:0] rdA;
    logic [15:0] rdB;
    logic        rsvErr;
  } vec_t;

  typedef struct packed {
    logic [15:0] rdA;
    logic [15:0] rdB;
    logic        rsvErr;
  } exp_t;

  exp_t expQ[$];
  vec_t mainVecs[19];
  vec_t zeroVecs[10];

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkVec(
    input logic we, input logic [2:0] wa, input logic [15:0] wd,
    input logic rea, input logic [2:0] raa, input logic reb, input logic [2:0] rab,
    input logic rse, input logic [2:0] rsa,
    input logic bA, input logic bB, input logic st,
    input logic [15:0] rdA, input logic [15:0] rdB, input logic err);
    vec_t v;
    v.we = we;   v.wa = wa;   v.wd = wd;
    v.rea = rea; v.raa = raa; v.reb = reb; v.rab = rab;
    v.rse = rse; v.rsa = rsa;
    v.busyA = bA; v.busyB = bB; v.stall = st;
    v.rdA = rdA; v.rdB = rdB; v.rsvErr = err;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic idleBus(input bit useZ);
    if (useZ) begin
      zBus.wr_en = 0; zBus.wr_addr = 0; zBus.wr_data = 0;
      zBus.rd_en_a = 0; zBus.rd_addr_a = 0; zBus.rd_en_b = 0; zBus.rd_addr_b = 0;
      zBus.rsv_en = 0; zBus.rsv_addr = 0;
    end else begin
      mBus.wr_en = 0; mBus.wr_addr = 0; mBus.wr_data = 0;
      mBus.rd_en_a = 0; mBus.rd_addr_a = 0; mBus.rd_en_b = 0; mBus.rd_addr_b = 0;
      mBus.rsv_en = 0; mBus.rsv_addr = 0;
    end
  endtask

  // Drive one vector on the chosen instance at the falling edge, check the
  // combinational flags, then check the registered results after the rising edge.
  task automatic applyStimulus(input vec_t v, input bit useZ, input string tag);
    exp_t e;
    @(negedge clk);
    idleBus(!useZ);
    if (useZ) begin
      zBus.wr_en = v.we; zBus.wr_addr = v.wa; zBus.wr_data = v.wd;
      zBus.rd_en_a = v.rea; zBus.rd_addr_a = v.raa;
      zBus.rd_en_b = v.reb; zBus.rd_addr_b = v.rab;
      zBus.rsv_en = v.rse; zBus.rsv_addr = v.rsa;
    end else begin
      mBus.wr_en = v.we; mBus.wr_addr = v.wa; mBus.wr_data = v.wd;
      mBus.rd_en_a = v.rea; mBus.rd_addr_a = v.raa;
      mBus.rd_en_b = v.reb; mBus.rd_addr_b = v.rab;
      mBus.rsv_en = v.rse; mBus.rsv_addr = v.rsa;
    end
    #1;
    checkOutput({tag, ".busy_a"}, 32'(useZ ? zBus.busy_a : mBus.busy_a), 32'(v.busyA));
    checkOutput({tag, ".busy_b"}, 32'(useZ ? zBus.busy_b : mBus.busy_b), 32'(v.busyB));
    checkOutput({tag, ".stall"},  32'(useZ ? zBus.stall  : mBus.stall),  32'(v.stall));
    e.rdA = v.rdA; e.rdB = v.rdB; e.rsvErr = v.rsvErr;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    checkOutput({tag, ".rd_data_a"}, 32'(useZ ? zBus.rd_data_a : mBus.rd_data_a), 32'(e.rdA));
    checkOutput({tag, ".rd_data_b"}, 32'(useZ ? zBus.rd_data_b : mBus.rd_data_b), 32'(e.rdB));
    checkOutput({tag, ".rsv_err"},   32'(useZ ? zBus.rsv_err   : mBus.rsv_err),   32'(e.rsvErr));
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    rst_n      = 1'b0;
    idleBus(1'b0);
    idleBus(1'b1);

    //                  we wa  wd        rea raa reb rab rse rsa bA bB st  rdA       rdB       err
    mainVecs[0]  = mkVec(0, 0, 16'h0000, 1, 3, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
    mainVecs[1]  = mkVec(1, 5, 16'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
    mainVecs[2]  = mkVec(0, 0, 16'h0000, 1, 5, 1, 5, 0, 0, 0, 0, 0, 16'h1234, 16'h1234, 0);
    mainVecs[3]  = mkVec(0, 0, 16'h0000, 1, 5, 0, 5, 0, 0, 0, 0, 0, 16'h1234, 16'h0000, 0);
    mainVecs[4]  = mkVec(1, 2, 16'hA5A5, 1, 2, 0, 0, 0, 0, 0, 0, 0, 16'hA5A5, 16'h0000, 0);
    mainVecs[5]  = mkVec(0, 0, 16'h0000, 0, 0, 1, 2, 0, 0, 0, 0, 0, 16'h0000, 16'hA5A5, 0);
    mainVecs[6]  = mkVec(0, 0, 16'h0000, 0, 0, 0, 0, 1, 4, 0, 0, 0, 16'h0000, 16'h0000, 0);
    mainVecs[7]  = mkVec(0, 0, 16'h0000, 1, 4, 1, 4, 0, 0, 1, 1, 1, 16'h0000, 16'h0000, 0);
    mainVecs[8]  = mkVec(1, 4, 16'h0042, 1, 4, 0, 0, 0, 0, 0, 0, 0, 16'h0042, 16'h0000, 0);
    mainVecs[9]  = mkVec(0, 0, 16'h0000, 1, 4, 0, 0, 0, 0, 0, 0, 0, 16'h0042, 16'h0000, 0);
    mainVecs[10] = mkVec(0, 0, 16'h0000, 0, 0, 0, 0, 1, 6, 0, 0, 0, 16'h0000, 16'h0000, 0);
    mainVecs[11] = mkVec(0, 0, 16'h0000, 0, 0, 1, 6, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 0);
    mainVecs[12] = mkVec(1, 6, 16'h0007, 1, 6, 0, 0, 1, 6, 0, 0, 0, 16'h0007, 16'h0000, 0);
    mainVecs[13] = mkVec(0, 0, 16'h0000, 1, 6, 0, 0, 0, 0, 1, 0, 1, 16'h0007, 16'h0000, 0);
    mainVecs[14] = mkVec(0, 0, 16'h0000, 0, 0, 0, 0, 1, 6, 0, 0, 0, 16'h0000, 16'h0000, 1);
    mainVecs[15] = mkVec(1, 6, 16'h0008, 1, 6, 0, 0, 0, 0, 0, 0, 0, 16'h0008, 16'h0000, 1);
    mainVecs[16] = mkVec(0, 0, 16'h0000, 1, 6, 1, 1, 0, 0, 0, 0, 0, 16'h0008, 16'h0000, 1);
    mainVecs[17] = mkVec(0, 0, 16'h0000, 1, 3, 0, 0, 1, 3, 0, 0, 0, 16'h0000, 16'h0000, 1);
    mainVecs[18] = mkVec(0, 0, 16'h0000, 1, 3, 1, 5, 0, 0, 1, 0, 1, 16'h0000, 16'h1234, 1);

    zeroVecs[0]  = mkVec(1, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
    zeroVecs[1]  = mkVec(0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
    zeroVecs[2]  = mkVec(1, 0, 16'hFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
    zeroVecs[3]  = mkVec(1, 1, 16'h1111, 1, 1, 0, 0, 0, 0, 0, 0, 0, 16'h1111, 16'h0000, 0);
    zeroVecs[4]  = mkVec(0, 0, 16'h0000, 0, 0, 1, 1, 1, 0, 0, 0, 0, 16'h0000, 16'h1111, 0);
    zeroVecs[5]  = mkVec(0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
    zeroVecs[6]  = mkVec(0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
    zeroVecs[7]  = mkVec(0, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0);
    zeroVecs[8]  = mkVec(0, 0, 16'h0000, 1, 1, 0, 0, 0, 0, 1, 0, 1, 16'h1111, 16'h0000, 0);
    zeroVecs[9]  = mkVec(0, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 0, 0, 0, 16'h0000, 16'h0000, 1);

    // A write attempted while reset is held must be ignored.
    mBus.wr_en = 1; mBus.wr_addr = 3; mBus.wr_data = 16'hBEEF;
    mBus.rd_en_a = 1; mBus.rd_addr_a = 3;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.rd_data_a", 32'(mBus.rd_data_a), 32'h0);
    checkOutput("reset.busy_a",    32'(mBus.busy_a),    32'h0);
    checkOutput("reset.rsv_err",   32'(mBus.rsv_err),   32'h0);
    @(negedge clk);
    idleBus(1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      applyStimulus(mainVecs[i], 1'b0, $sformatf("main[%0d]", i));
    end

    // Reset in the middle of a cycle: r3 is busy, port B holds r5 data and the
    // sticky error is set. All of it must clear without waiting for a clock edge.
    @(negedge clk);
    mBus.rd_en_a = 1; mBus.rd_addr_a = 3;
    #1;
    checkOutput("midrst.busy_before", 32'(mBus.busy_a), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst.busy_a",    32'(mBus.busy_a),    32'h0);
    checkOutput("midrst.stall",     32'(mBus.stall),     32'h0);
    checkOutput("midrst.rd_data_b", 32'(mBus.rd_data_b), 32'h0);
    checkOutput("midrst.rsv_err",   32'(mBus.rsv_err),   32'h0);
    @(posedge clk);
    @(negedge clk);
    idleBus(1'b0);
    rst_n = 1'b1;
    applyStimulus(mkVec(0, 0, 16'h0000, 1, 5, 1, 3, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0),
                  1'b0, "postrst");

    for (int i = 0; i < 10; i++) begin
      applyStimulus(zeroVecs[i], 1'b1, $sformatf("zero[%0d]", i));
    end

    @(negedge clk);
    idleBus(1'b0);
    idleBus(1'b1);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
